reg_dump_reader: RTL

// - Read-out end of the register file: on request, sweeps all registers through the debug read port
//   and streams them as bytes to the UART transmitter.
// - Sits in the debug unit, between the register file debug port and the UART TX handshake.
// - Each word is captured once, then sent DATA_W/BYTE_W bytes, MSB first, registers in ascending order.

---
 rtl/reg_dump_reader_pkg.sv | 18 +
 rtl/reg_dump_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared debug-unit definitions for the register dump reader.
// Holds the data/byte geometry of a register word and the FSM state encoding.
package reg_dump_reader_pkg;

    localparam int BYTE_W     = 8;
    localparam int DATA_W     = 32;
    localparam int BPW        = DATA_W / BYTE_W;
    localparam int BYTE_IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_NEXT = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: on i_start, sweeps registers 0..N_REGS-1 through the
// register file debug read port and streams each word to the UART transmitter
// as BPW bytes, MSB first.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             dump request, honoured in IDLE only
//   o_busy, o_done      busy outside IDLE; one-cycle pulse at end of a dump
//   o_dbg_reg_addr      debug read address (data returns the following cycle)
//   i_dbg_reg_data      debug read data
//   o_tx_data           byte presented to the transmitter
//   o_tx_start          one-cycle transmit request
//   i_tx_done           transmitter finished current byte, honoured in WAIT only
//
// state | meaning
// IDLE  | waiting for i_start
// ADDR  | debug address presented for reg_idx
// LOAD  | read data captured into word
// SEND  | o_tx_start pulse for byte byte_idx
// WAIT  | waiting for i_tx_done
// NEXT  | advance byte / register / finish
// DONE  | o_done pulse
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int N_REGS     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [REG_ADDR_W-1:0] o_dbg_reg_addr,
    input  logic [DATA_W-1:0]     i_dbg_reg_data,
    output logic [BYTE_W-1:0]     o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done
);

    localparam logic [REG_ADDR_W-1:0] LAST_REG  = REG_ADDR_W'(N_REGS - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BPW - 1);

    logic [2:0]            state;
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [DATA_W-1:0]     word;
    logic [DATA_W-1:0]     word_shl;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            reg_idx        <= '0;
            byte_idx       <= '0;
            word           <= '0;
            o_dbg_reg_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        reg_idx        <= '0;
                        byte_idx       <= '0;
                        o_dbg_reg_addr <= '0;
                        state          <= ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_LOAD;
                ST_LOAD: begin
                    word  <= i_dbg_reg_data;
                    state <= ST_SEND;
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_done) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (byte_idx != LAST_BYTE) begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= ST_SEND;
                    end else if (reg_idx != LAST_REG) begin
                        // Address is updated together with reg_idx so that it is
                        // already stable during ADDR and the data is ready in LOAD.
                        byte_idx       <= '0;
                        reg_idx        <= reg_idx + 1'b1;
                        o_dbg_reg_addr <= reg_idx + 1'b1;
                        state          <= ST_ADDR;
                    end else begin
                        byte_idx <= '0;
                        reg_idx  <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte select: shift the wanted byte up to the top of the word. Driven only
    // by registers, so o_tx_data holds from SEND through the NEXT cycle.
    assign word_shl   = word << (BYTE_W * byte_idx);
    assign o_tx_data  = word_shl[DATA_W-1 -: BYTE_W];

    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_tx_start = (state == ST_SEND);

endmodule
